// File: rtl/fifo_axis_reader_if.sv
// fifo_axis_reader_if: AXI4-Stream bundle presented by the FIFO drain stage
interface fifo_axis_reader_if #(
   parameter int WIDTH      = 512,
   parameter int KEEP_WIDTH = WIDTH / 8
);
   logic [WIDTH-1:0]      tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   modport master (output tdata, tkeep, tvalid, tlast, input tready);
   modport slave (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains a registered-read FIFO into a 3-entry queue and streams it out as framed AXI4-Stream
module fifo_axis_reader #(
   parameter int WIDTH      = 512,
   parameter int KEEP_WIDTH = WIDTH / 8,
   parameter int PKT_BEATS  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fifo_empty,
   output logic                fifo_rd_en,
   input  logic [WIDTH-1:0]    fifo_data,
   fifo_axis_reader_if.master  m_axis,
   output logic [31:0]         frame_count,
   output logic                busy
);
   localparam int CW = PKT_BEATS > 1 ? $clog2(PKT_BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(PKT_BEATS - 1);

   logic [WIDTH-1:0] mem [3];
   logic [1:0]       head, tail, occ;
   logic             inflight, valid, pop, last;
   logic [CW-1:0]    beat_cnt;
   logic [31:0]      frame_cnt;

   function automatic logic [1:0] nxt(input logic [1:0] p);
      return p == 2'd2 ? 2'd0 : p + 2'd1;
   endfunction

   // reads and pending words together never exceed the queue depth, so a capture always has room
   assign fifo_rd_en  = !rst && !fifo_empty && ({1'b0, occ} + {2'b0, inflight}) < 3'd3;
   assign valid       = occ != 2'd0;
   assign pop         = valid && m_axis.tready;
   assign last        = beat_cnt == LAST;
   assign frame_count = frame_cnt;
   assign busy        = beat_cnt != '0 || valid || inflight;

   // queue bookkeeping: pointers, occupancy and the one-cycle read-latency marker
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head     <= 2'd0;
         tail     <= 2'd0;
         occ      <= 2'd0;
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         if (inflight) tail <= nxt(tail);
         if (pop) head <= nxt(head);
         occ <= occ + {1'b0, inflight} - {1'b0, pop};
      end
   end

   // storage: the word returned for last cycle's read lands at the tail
   always_ff @(posedge clk) begin
      if (inflight) mem[tail] <= fifo_data;
   end

   // framing: beat position inside the frame and the wrapping frame counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt  <= '0;
         frame_cnt <= 32'd0;
      end else if (pop) begin
         beat_cnt  <= last ? '0 : beat_cnt + 1'b1;
         frame_cnt <= frame_cnt + {31'd0, last};
      end
   end

   // stream outputs come from the head entry and read as zero when nothing is presented
   always_comb begin
      m_axis.tvalid = valid;
      m_axis.tdata  = valid ? mem[head] : '0;
      m_axis.tkeep  = valid ? '1 : '0;
      m_axis.tlast  = valid && last;
   end
endmodule

// File: tb/tb_fifo_axis_reader.sv
// tb_fifo_axis_reader: directed and table-driven checks of the FIFO-to-AXIS drain stage
`timescale 1ns/1ps
module tb_fifo_axis_reader;
   localparam int W = 32;

   typedef struct {
      int k;
      int n;
      int gap;
      int frames;
      int busy;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic [2:0] f_empty, f_rd, busy;
   logic [2:0] ready = 3'b000;
   logic [2:0][W-1:0] f_data = '0;
   logic [2:0][31:0] frames;
   logic [W-1:0] mem [3][2048];
   int wr_p [3] = '{0, 0, 0};
   int rd_p [3] = '{0, 0, 0};
   int pushed [3] = '{0, 0, 0};
   int exp_next [3] = '{0, 0, 0};
   int beat_idx [3] = '{0, 0, 0};
   int outst [3] = '{0, 0, 0};
   logic [2:0] held = 3'b000;
   logic [2:0][W-1:0] held_d = '0;
   logic [2:0] tv, tl;
   logic [2:0][W-1:0] td;
   logic [2:0][W/8-1:0] tk;
   int n_chk = 0;
   int n_fail = 0;
   vec_t tbl [6];

   fifo_axis_reader_if #(.WIDTH(W)) ax0 ();
   fifo_axis_reader_if #(.WIDTH(W)) ax1 ();
   fifo_axis_reader_if #(.WIDTH(W)) ax2 ();

   fifo_axis_reader #(.WIDTH(W), .PKT_BEATS(16)) dut0 (.clk(clk), .rst(rst), .fifo_empty(f_empty[0]), .fifo_rd_en(f_rd[0]),
      .fifo_data(f_data[0]), .m_axis(ax0.master), .frame_count(frames[0]), .busy(busy[0]));
   fifo_axis_reader #(.WIDTH(W), .PKT_BEATS(4)) dut1 (.clk(clk), .rst(rst), .fifo_empty(f_empty[1]), .fifo_rd_en(f_rd[1]),
      .fifo_data(f_data[1]), .m_axis(ax1.master), .frame_count(frames[1]), .busy(busy[1]));
   fifo_axis_reader #(.WIDTH(W), .PKT_BEATS(1)) dut2 (.clk(clk), .rst(rst), .fifo_empty(f_empty[2]), .fifo_rd_en(f_rd[2]),
      .fifo_data(f_data[2]), .m_axis(ax2.master), .frame_count(frames[2]), .busy(busy[2]));

   assign ax0.tready = ready[0];
   assign ax1.tready = ready[1];
   assign ax2.tready = ready[2];
   assign tv = {ax2.tvalid, ax1.tvalid, ax0.tvalid};
   assign tl = {ax2.tlast, ax1.tlast, ax0.tlast};
   assign td = {ax2.tdata, ax1.tdata, ax0.tdata};
   assign tk = {ax2.tkeep, ax1.tkeep, ax0.tkeep};
   assign f_empty[0] = rd_p[0] == wr_p[0];
   assign f_empty[1] = rd_p[1] == wr_p[1];
   assign f_empty[2] = rd_p[2] == wr_p[2];

   always #5 clk = ~clk;

   // FIFO read-port model: registered data one cycle after an accepted read, emptied by flush
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (flush) rd_p[k] <= wr_p[k];
         else if (f_rd[k]) begin
            f_data[k] <= mem[k][rd_p[k]];
            rd_p[k] <= rd_p[k] + 1;
         end
      end
   end

   function automatic int pb(int k);
      return k == 0 ? 16 : k == 1 ? 4 : 1;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(int k, int n);
      for (int i = 0; i < n; i++) begin
         mem[k][wr_p[k]] = pushed[k];
         wr_p[k]++;
         pushed[k]++;
      end
   endtask

   task automatic wait_done(int k, int budget);
      int c = 0;
      while (exp_next[k] != pushed[k] && c < budget) begin
         @(negedge clk);
         c++;
      end
      check($sformatf("drain%0d", k), 64'(exp_next[k] != pushed[k]), 0);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (rst) begin
               outst[k] = 0;
               held[k] = 1'b0;
               beat_idx[k] = 0;
               if (flush) exp_next[k] = pushed[k];
            end else begin
               if (f_rd[k]) check($sformatf("rd_nonempty%0d", k), 64'(f_empty[k]), 0);
               if (outst[k] == 3) check($sformatf("rd_credit%0d", k), 64'(f_rd[k]), 0);
               if (held[k]) begin
                  check($sformatf("stall_valid%0d", k), 64'(tv[k]), 1);
                  check($sformatf("stall_data%0d", k), 64'(td[k]), 64'(held_d[k]));
               end
               if (tv[k] && ready[k]) begin
                  check($sformatf("beat_data%0d", k), 64'(td[k]), 64'(exp_next[k]));
                  check($sformatf("beat_last%0d", k), 64'(tl[k]), 64'((beat_idx[k] % pb(k)) == pb(k) - 1));
                  check($sformatf("beat_keep%0d", k), 64'(tk[k]), 64'({(W/8){1'b1}}));
                  exp_next[k]++;
                  beat_idx[k]++;
               end
               held[k] = tv[k] && !ready[k];
               held_d[k] = td[k];
               outst[k] += int'(f_rd[k]) - int'(tv[k] && ready[k]);
            end
         end
      end
   endtask

   initial begin
      int gap;
      int c;
      tbl[0] = '{1, 8, 4, 2, 0};
      tbl[1] = '{1, 6, 4, 3, 1};
      tbl[2] = '{1, 2, 1, 4, 0};
      tbl[3] = '{2, 5, 1, 5, 0};
      tbl[4] = '{2, 3, 3, 8, 0};
      tbl[5] = '{1, 4, 0, 5, 0};
      fork
         monitor();
      join_none
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_valid%0d", k), 64'(tv[k]), 0);
         check($sformatf("rst_last%0d", k), 64'(tl[k]), 0);
         check($sformatf("rst_data%0d", k), 64'(td[k]), 0);
         check($sformatf("rst_frames%0d", k), 64'(frames[k]), 0);
         check($sformatf("rst_busy%0d", k), 64'(busy[k]), 0);
      end
      push(0, 32);
      #1 check("rst_rd_en", 64'(f_rd[0]), 0);
      ready[0] = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      #1 check("lat_rd_N", 64'(f_rd[0]), 1);
      check("lat_valid_N", 64'(tv[0]), 0);
      @(posedge clk);
      @(negedge clk) check("lat_valid_N1", 64'(tv[0]), 0);
      @(negedge clk) check("lat_valid_N2", 64'(tv[0]), 1);
      check("lat_data_N2", 64'(td[0]), 0);
      gap = 0;
      repeat (31) begin
         @(negedge clk);
         if (!tv[0]) gap++;
      end
      check("b2b_gaps", 64'(gap), 0);
      wait_done(0, 100);
      check("seq_frames", 64'(frames[0]), 2);
      check("seq_busy", 64'(busy[0]), 0);

      push(0, 1008);
      c = 0;
      while (exp_next[0] != pushed[0] && c < 20000) begin
         @(posedge clk);
         #1 ready[0] = 1'($urandom_range(0, 1));
         c++;
      end
      ready[0] = 1'b1;
      wait_done(0, 100);
      check("rand_frames", 64'(frames[0]), 65);
      check("rand_busy", 64'(busy[0]), 0);

      @(posedge clk);
      #1 ready[0] = 1'b0;
      push(0, 6);
      repeat (6) @(posedge clk);
      #1 check("bp_rd_off", 64'(f_rd[0]), 0);
      check("bp_valid", 64'(tv[0]), 1);
      check("bp_head", 64'(td[0]), 1040);
      ready[0] = 1'b1;
      #1 check("bp_rd_R", 64'(f_rd[0]), 0);
      @(posedge clk);
      #1 check("bp_rd_R1", 64'(f_rd[0]), 1);
      wait_done(0, 100);
      check("bp_busy_midframe", 64'(busy[0]), 1);
      check("bp_frames", 64'(frames[0]), 65);

      @(posedge clk);
      #1 ready[0] = 1'b0;
      push(0, 4);
      repeat (6) @(posedge clk);
      #1 ready[0] = 1'b1;
      @(posedge clk);
      #1 ready[0] = 1'b0;
      check("pre_rst_rd", 64'(f_rd[0]), 1);
      @(posedge clk);
      #1 check("pre_rst_valid", 64'(tv[0]), 1);
      check("pre_rst_busy", 64'(busy[0]), 1);
      rst = 1'b1;
      flush = 1'b1;
      #1 check("arst_valid", 64'(tv[0]), 0);
      check("arst_last", 64'(tl[0]), 0);
      check("arst_data", 64'(td[0]), 0);
      check("arst_frames", 64'(frames[0]), 0);
      check("arst_busy", 64'(busy[0]), 0);
      check("arst_rd", 64'(f_rd[0]), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      flush = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("drop_valid", 64'(tv[0]), 0);
      end
      check("drop_busy", 64'(busy[0]), 0);
      ready[0] = 1'b1;
      push(0, 16);
      wait_done(0, 200);
      check("restart_frames", 64'(frames[0]), 1);
      check("restart_busy", 64'(busy[0]), 0);

      ready[1] = 1'b1;
      ready[2] = 1'b1;
      foreach (tbl[i]) begin
         for (int j = 0; j < tbl[i].n; j++) begin
            push(tbl[i].k, 1);
            repeat (tbl[i].gap) @(posedge clk);
            #1;
         end
         wait_done(tbl[i].k, 200);
         check($sformatf("tbl%0d_frames", i), 64'(frames[tbl[i].k]), 64'(tbl[i].frames));
         check($sformatf("tbl%0d_busy", i), 64'(busy[tbl[i].k]), 64'(tbl[i].busy));
      end

      force dut0.frame_cnt = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut0.frame_cnt;
      @(negedge clk);
      check("wrap_pre", 64'(frames[0]), 64'hFFFF_FFFF);
      push(0, 16);
      wait_done(0, 200);
      check("wrap_frames", 64'(frames[0]), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_axis_reader.md
# fifo_axis_reader

Read-side drain stage for the application clock-domain-crossing FIFO: pulls words from the FIFO read port (registered, one-cycle read latency, `empty` flag), buffers them in a 3-entry output queue and presents them as an AXI4-Stream master with fixed-length framing (`tlast`). It sits directly downstream of the async FIFO in the read clock domain and feeds the application's AXI-Stream datapath at one beat per cycle when unthrottled.

## Interface
- `WIDTH`, 512: FIFO word / `tdata` width in bits; multiple of 8.
- `KEEP_WIDTH`, `WIDTH/8`: `tkeep` width.
- `PKT_BEATS`, 16: beats per frame; `tlast` on the last beat; legal range 1..65536.

- `clk`  in  1: one clock, the FIFO read clock.
- `rst`  in  1: reset is asynchronous and active-high.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_en`  out  1: FIFO read request.
- `fifo_data`  in  WIDTH: FIFO read data, valid the cycle after an accepted read.
- `m_axis_tdata`  out  WIDTH: stream data.
- `m_axis_tkeep`  out  KEEP_WIDTH: all ones whenever `tvalid`.
- `m_axis_tvalid`  out  1: stream valid.
- `m_axis_tready`  in  1: stream ready.
- `m_axis_tlast`  out  1: last beat of frame.
- `frame_count`  out  32: frames completed, wraps modulo 2^32.
- `busy`  out  1: a frame is partially sent, or the queue or a read is non-empty.

## Operation
- Read issue: `fifo_rd_en = !fifo_empty && (occ + inflight) < 3`. `occ` is queue occupancy, 0..3. `inflight` is a register set to the previous cycle's `fifo_rd_en`. No combinational path from `m_axis_tready` to `fifo_rd_en`.
- Capture: when `inflight` = 1, `fifo_data` is written to the queue tail that cycle. The credit rule above guarantees this write never overflows.
- Queue: 3-entry circular buffer, 2-bit head/tail pointers wrapping 2→0. The head entry drives `m_axis_tdata`. `m_axis_tvalid = (occ != 0)` and is registered.
- Handshake: a beat transfers on `tvalid && tready`; this pops the head. A pop and a capture in the same cycle leave `occ` unchanged. Once `tvalid` is high, it and `tdata` stay stable until the transfer.
- Framing: `beat_cnt` counts transferred beats, `max(1,clog2(PKT_BEATS))` bits. `tlast = (beat_cnt == PKT_BEATS-1)`. When `PKT_BEATS` = 1, `tlast` is constantly 1 while valid. On a `tlast` transfer, `beat_cnt` goes to 0 and `frame_count` increments, wrapping 0xFFFFFFFF→0.
- `busy = (beat_cnt != 0) || occ != 0 || inflight`.
- Reset: clears `occ`, pointers, `inflight`, `beat_cnt` and `frame_count` immediately. If a read was issued before reset, its data returns after reset is released; that data is discarded because `inflight` was cleared. The FIFO shares this reset.

## Timing
- Reset values: `fifo_rd_en` 0 while `rst` is high, `m_axis_tvalid` 0, `m_axis_tlast` 0, `m_axis_tdata` 0, `frame_count` 0, `busy` 0.
- Latency: `fifo_empty` falls in cycle N with the queue idle. `fifo_rd_en` = 1 in N, data is captured at the end of N+1, and `tvalid` = 1 in N+2.
- Throughput: with `tready` held high and the FIFO non-empty, steady state is `occ` = 1 and `inflight` = 1, giving one beat per cycle.
- Backpressure: `tready` low with 3 words held or in flight means `fifo_rd_en` = 0. When `tready` returns, the first pop occurs that cycle and a new read issues the next cycle.
- Empty mid-stream: `tvalid` drops after the queue drains. `beat_cnt` is preserved, and the frame resumes with no spurious `tlast`.

## Test plan
- Reset, then 32 words 0..31 pre-loaded, `tready` = 1, `PKT_BEATS` = 16 → first `tvalid` 2 cycles after the first `fifo_rd_en`; beats 0..31 appear back-to-back; `tlast` on data 15 and 31; `frame_count` = 2; `busy` = 0 at the end.
- Random `tready`, 50% duty, over 1000 words → output order matches input exactly; `fifo_rd_en` never asserts when `occ + inflight` = 3; no capture when the queue is full; `tvalid`/`tdata` stable while stalled.
- Words trickled one every 4 cycles with `PKT_BEATS` = 4 → `tvalid` gaps occur, `tlast` only on every 4th word, `frame_count` increments once per 4 words.
- `PKT_BEATS` = 1 with 5 words → `tlast` = 1 on every beat; `frame_count` = 5.
- `rst` pulsed asynchronously mid-frame (beat 7, 2 words queued, 1 in flight) → all outputs 0 immediately; the returning word is dropped; a frame restarted after reset has `tlast` on its 16th beat.
- `frame_count` forced to 0xFFFFFFFF, then one frame sent → `frame_count` = 0.
